alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational Hack-style ALU.
// Each grant takes IDLE -> EXEC -> RESP. The response is held until the consumer accepts it.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_x,
   input  logic [15:0] req0_y,
   input  logic [5:0]  req0_ctl,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_x,
   input  logic [15:0] req1_y,
   input  logic [5:0]  req1_ctl,
   output logic [15:0] alu_x,
   output logic [15:0] alu_y,
   output logic [5:0]  alu_ctl,
   input  logic [15:0] alu_o,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_o,
   output logic        rsp_zr,
   output logic        rsp_ng
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        ptr_q, ptr_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [5:0]  ctl_q, ctl_d;
   logic        id_q, id_d;
   logic [15:0] rsp_o_q, rsp_o_d;
   logic        rsp_zr_q, rsp_zr_d;
   logic        rsp_ng_q, rsp_ng_d;
   logic        rsp_id_q, rsp_id_d;

   logic        grant_any;
   logic        grant_id;
   logic        grant_fire;

   // The pointer only breaks ties. A lone requester always wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) grant_id = ptr_q;
      else                          grant_id = req1_valid;
   end

   // NOTE: ready is gated by rst_n. Reset is synchronous, so state_q can still read IDLE while rst_n is low.
   assign grant_fire = rst_n && (state_q == IDLE) && grant_any;
   assign req0_ready = grant_fire && !grant_id;
   assign req1_ready = grant_fire &&  grant_id;

   // NOTE: every signal gets a default first. Without one, a path that skips an assignment infers a latch.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      x_d      = x_q;
      y_d      = y_q;
      ctl_d    = ctl_q;
      id_d     = id_q;
      rsp_o_d  = rsp_o_q;
      rsp_zr_d = rsp_zr_q;
      rsp_ng_d = rsp_ng_q;
      rsp_id_d = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               x_d     = grant_id ? req1_x   : req0_x;
               y_d     = grant_id ? req1_y   : req0_y;
               ctl_d   = grant_id ? req1_ctl : req0_ctl;
               id_d    = grant_id;
               ptr_d   = ~grant_id;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_o_d  = alu_o;
            rsp_zr_d = (alu_o == 16'd0);
            rsp_ng_d = alu_o[15];
            rsp_id_d = id_q;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments, so every flop samples its pre-edge value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         ctl_q    <= '0;
         id_q     <= 1'b0;
         rsp_o_q  <= '0;
         rsp_zr_q <= 1'b0;
         rsp_ng_q <= 1'b0;
         rsp_id_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ctl_q    <= ctl_d;
         id_q     <= id_d;
         rsp_o_q  <= rsp_o_d;
         rsp_zr_q <= rsp_zr_d;
         rsp_ng_q <= rsp_ng_d;
         rsp_id_q <= rsp_id_d;
      end
   end

   // The latched operands drive the ALU directly, so they hold their last values outside EXEC.
   assign alu_x     = x_q;
   assign alu_y     = y_q;
   assign alu_ctl   = ctl_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_o     = rsp_o_q;
   assign rsp_zr    = rsp_zr_q;
   assign rsp_ng    = rsp_ng_q;

endmodule
